// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus arbiter: FSM state encoding,
// default bus width and a constant clog2 helper for port sizing.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Returns at least 1 so that index ports never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder. The search starts
// just after last_grant and wraps; the first asserted request wins.
module rr_picker
  import reg_bus_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               valid,
  output logic [IDW-1:0]     winner
);

  logic [IDW-1:0] cand;

  // Walk from the farthest position back to the nearest so the nearest
  // asserted requester after last_grant is the last one written.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDW'((int'(last_grant) + off) % NUM_REQ);
      if (req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one internal data bus among NUM_REQ requesters and
// pulses a single register load (or clear) enable per transaction, followed
// by a four-phase req/ack handshake with the winner.
//
// Optional feature macro: ARB_CLEAR_EN adds input_clr_req; a set clr_req
// turns the transaction into a register clear with the bus driven to zero.
//
//   state | meaning
//   IDLE  | no transaction; round-robin search over input_req each cycle
//   LOAD  | one cycle: bus holds winner's byte, one enable/clear is high
//   ACK   | ack[winner] high until input_req[winner] is sampled low
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  NUM_REG    = 4,
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int REQ_W      = clog2(NUM_REQ),
  localparam int REG_W      = clog2(NUM_REG)
) (
  input  logic                          clock,
  input  logic                          input_reset_n,
  input  logic [NUM_REQ-1:0]            input_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] input_data,
  input  logic [NUM_REQ*REG_W-1:0]      input_target,
`ifdef ARB_CLEAR_EN
  input  logic [NUM_REQ-1:0]            input_clr_req,
`endif
  output logic [NUM_REQ-1:0]            output_ack,
  output logic [DATA_WIDTH-1:0]         output_bus,
  output logic [NUM_REG-1:0]            output_clock_enable,
  output logic [NUM_REG-1:0]            output_clear,
  output logic                          output_busy,
  output logic [REQ_W-1:0]              output_grant_id
);

  state_t                  state_q, state_d;
  logic [REQ_W-1:0]        last_grant_q;
  logic                    pick_valid;
  logic [REQ_W-1:0]        pick_id;
  logic [DATA_WIDTH-1:0]   pick_data;
  logic [REG_W-1:0]        pick_target;
  logic [NUM_REG-1:0]      pick_oh;
  logic                    start;
  logic [NUM_REQ-1:0]      ack_d;
  logic [NUM_REG-1:0]      ce_d;
  logic [NUM_REG-1:0]      clr_d;
  logic [DATA_WIDTH-1:0]   bus_d;
  logic                    busy_d;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (input_req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  assign pick_data   = input_data[int'(pick_id)*DATA_WIDTH +: DATA_WIDTH];
  assign pick_target = input_target[int'(pick_id)*REG_W +: REG_W];

  // Next state and next values of every registered output. The winner's
  // byte and target are captured straight into the output registers on
  // entry to LOAD, so requester inputs are ignored after the grant.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ack_d   = '0;
    ce_d    = '0;
    clr_d   = '0;
    bus_d   = output_bus;
    pick_oh = '0;
    pick_oh[pick_target] = 1'b1;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = LOAD;
          start   = 1'b1;
`ifdef ARB_CLEAR_EN
          if (input_clr_req[pick_id]) begin
            clr_d = pick_oh;
            bus_d = '0;
          end else begin
            ce_d  = pick_oh;
            bus_d = pick_data;
          end
`else
          ce_d  = pick_oh;
          bus_d = pick_data;
`endif
        end
      end
      LOAD: begin
        state_d = ACK;
        ack_d[output_grant_id] = 1'b1;
      end
      ACK: begin
        if (input_req[output_grant_id]) ack_d[output_grant_id] = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops every enable immediately so an
  // interrupted LOAD never reaches the register bank.
  always_ff @(posedge clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state_q             <= IDLE;
      last_grant_q        <= REQ_W'(NUM_REQ - 1);
      output_ack          <= '0;
      output_bus          <= '0;
      output_clock_enable <= '0;
      output_clear        <= '0;
      output_busy         <= 1'b0;
      output_grant_id     <= '0;
    end else begin
      state_q             <= state_d;
      output_ack          <= ack_d;
      output_bus          <= bus_d;
      output_clock_enable <= ce_d;
      output_clear        <= clr_d;
      output_busy         <= busy_d;
      if (start) begin
        last_grant_q    <= pick_id;
        output_grant_id <= pick_id;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter. Stimulus pushes the expected LOAD
// (winner, bus, enable, clear) in round-robin order; a negedge monitor pops
// and compares whenever an enable or clear is presented.
module tb_reg_bus_arbiter;
  import reg_bus_pkg::*;

  logic        clock = 1'b0;
  logic        input_reset_n;
  logic [3:0]  input_req;
  logic [31:0] input_data;
  logic [7:0]  input_target;
  logic [3:0]  input_clr_req;
  logic [3:0]  output_ack;
  logic [7:0]  output_bus;
  logic [3:0]  output_clock_enable;
  logic [3:0]  output_clear;
  logic        output_busy;
  logic [1:0]  output_grant_id;

  always #5 clock = ~clock;

  reg_bus_arbiter #(.NUM_REQ(4), .NUM_REG(4), .DATA_WIDTH(8)) dut (
    .clock               (clock),
    .input_reset_n       (input_reset_n),
    .input_req           (input_req),
    .input_data          (input_data),
    .input_target        (input_target),
`ifdef ARB_CLEAR_EN
    .input_clr_req       (input_clr_req),
`endif
    .output_ack          (output_ack),
    .output_bus          (output_bus),
    .output_clock_enable (output_clock_enable),
    .output_clear        (output_clear),
    .output_busy         (output_busy),
    .output_grant_id     (output_grant_id)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] bus;
    logic [3:0] ce;
    logic [3:0] clr;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] auto_rel = 4'h0;
  logic [7:0] bank [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input int tgt, input bit clr);
    exp_t       e;
    logic [3:0] oh;
    oh    = 4'b0001 << tgt;
    e.id  = 2'(id);
    e.bus = clr ? 8'h00 : d;
    e.ce  = clr ? 4'h0 : oh;
    e.clr = clr ? oh : 4'h0;
    sb_q.push_back(e);
  endtask

  task automatic raise(input int i, input logic [7:0] d, input int tgt, input bit clr);
    input_data[i*8 +: 8]   = d;
    input_target[i*2 +: 2] = 2'(tgt);
    input_clr_req[i]       = clr;
    input_req[i]           = 1'b1;
  endtask

  task automatic do_reset();
    input_reset_n = 1'b0;
    repeat (2) @(negedge clock);
    input_reset_n = 1'b1;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((sb_q.size() != 0 || output_busy) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("drain_in_budget", {31'd0, (sb_q.size() == 0 && !output_busy)}, 32'd1);
  endtask

  // Register bank model fed by the DUT's bus and enables.
  always @(posedge clock) begin
    for (int j = 0; j < 4; j++) begin
      if (output_clock_enable[j]) bank[j] = output_bus;
      if (output_clear[j])        bank[j] = 8'h00;
    end
  end

  // Monitor/scoreboard plus automatic requester release on ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (input_reset_n && ((output_clock_enable | output_clear) != 4'h0)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_load: ce=%b clr=%b bus=0x%0h expected no load",
                   output_clock_enable, output_clear, output_bus);
        end else begin
          e = sb_q.pop_front();
          check("load_bus",      output_bus,          e.bus);
          check("load_ce",       output_clock_enable, e.ce);
          check("load_clr",      output_clear,        e.clr);
          check("load_grant_id", output_grant_id,     e.id);
        end
      end
      for (int i = 0; i < 4; i++)
        if (output_ack[i] && auto_rel[i]) input_req[i] = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    input_req     = '0;
    input_data    = '0;
    input_target  = '0;
    input_clr_req = '0;
    for (int j = 0; j < 4; j++) bank[j] = 8'h00;

    // Reset state
    do_reset();
    check("rst_ack",      output_ack,          32'h0);
    check("rst_ce",       output_clock_enable, 32'h0);
    check("rst_clr",      output_clear,        32'h0);
    check("rst_bus",      output_bus,          32'h0);
    check("rst_busy",     output_busy,         32'h0);
    check("rst_grant_id", output_grant_id,     32'h0);

    // Single load: requester 0, data A5 to register 2
    auto_rel = 4'h0;
    raise(0, 8'hA5, 2, 1'b0);
    push(0, 8'hA5, 2, 1'b0);
    @(posedge clock); #1;
    check("t1_load_ce",   output_clock_enable, 32'h4);
    check("t1_load_ack",  output_ack,          32'h0);
    check("t1_load_busy", output_busy,         32'h1);
    @(posedge clock); #1;
    check("t1_ack_ce",    output_clock_enable, 32'h0);
    check("t1_ack_ack",   output_ack,          32'h1);
    check("t1_bus_held",  output_bus,          32'hA5);
    @(negedge clock);
    input_req[0] = 1'b0;
    @(posedge clock); #1;
    check("t1_rel_ack",   output_ack,          32'h0);
    check("t1_rel_busy",  output_busy,         32'h0);
    @(negedge clock);
    check("t1_bank2",     bank[2],             32'hA5);

    // All four requesting at once after reset: order 0,1,2,3
    do_reset();
    auto_rel = 4'hF;
    for (int i = 0; i < 4; i++) raise(i, 8'(8'h11 * (i + 1)), i, 1'b0);
    push(0, 8'h11, 0, 1'b0);
    push(1, 8'h22, 1, 1'b0);
    push(2, 8'h33, 2, 1'b0);
    push(3, 8'h44, 3, 1'b0);
    wait_drain();
    check("t2_bank0", bank[0], 32'h11);
    check("t2_bank1", bank[1], 32'h22);
    check("t2_bank2", bank[2], 32'h33);
    check("t2_bank3", bank[3], 32'h44);
    check("t2_last_grant", output_grant_id, 32'h3);

    // Requester 1 served, then 1 and 2 together: 2 must win first
    @(negedge clock);
    raise(1, 8'h3C, 3, 1'b0);
    push(1, 8'h3C, 3, 1'b0);
    wait_drain();
    @(negedge clock);
    raise(1, 8'h6B, 0, 1'b0);
    raise(2, 8'h5A, 3, 1'b0);
    push(2, 8'h5A, 3, 1'b0);
    push(1, 8'h6B, 0, 1'b0);
    wait_drain();
    check("t3_bank0", bank[0], 32'h6B);
    check("t3_bank3", bank[3], 32'h5A);

    // Requester 3 holds req for 5 cycles after ack
    @(negedge clock);
    auto_rel = 4'h7;
    raise(3, 8'h77, 1, 1'b0);
    push(3, 8'h77, 1, 1'b0);
    @(posedge clock); #1;
    check("t4_load_ce", output_clock_enable, 32'h2);
    @(posedge clock); #1;
    check("t4_ack_first", output_ack, 32'h8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check("t4_ack_held",  output_ack,  32'h8);
      check("t4_busy_held", output_busy, 32'h1);
    end
    @(negedge clock);
    input_req[3] = 1'b0;
    @(posedge clock); #1;
    check("t4_rel_ack",  output_ack,  32'h0);
    check("t4_rel_busy", output_busy, 32'h0);
    check("t4_bank1",    bank[1],     32'h77);

    // Reset during LOAD aborts the write; next grant goes to requester 0
    @(negedge clock);
    auto_rel = 4'h0;
    raise(2, 8'hEE, 0, 1'b0);
    @(posedge clock); #1;
    check("t5_in_load_ce", output_clock_enable, 32'h1);
    input_reset_n = 1'b0;
    #1;
    check("t5_rst_ce",   output_clock_enable, 32'h0);
    check("t5_rst_ack",  output_ack,          32'h0);
    check("t5_rst_busy", output_busy,         32'h0);
    @(negedge clock);
    input_req[2]  = 1'b0;
    input_reset_n = 1'b1;
    check("t5_bank0_kept", bank[0], 32'h6B);
    @(negedge clock);
    auto_rel = 4'hF;
    raise(0, 8'h99, 2, 1'b0);
    raise(2, 8'hEE, 0, 1'b0);
    push(0, 8'h99, 2, 1'b0);
    push(2, 8'hEE, 0, 1'b0);
    wait_drain();
    check("t5_bank0", bank[0], 32'hEE);
    check("t5_bank2", bank[2], 32'h99);

`ifdef ARB_CLEAR_EN
    // Clear transaction: requester 3 clears register 1
    @(negedge clock);
    raise(3, 8'hC3, 1, 1'b1);
    push(3, 8'hC3, 1, 1'b1);
    @(posedge clock); #1;
    check("t6_clear",  output_clear,        32'h2);
    check("t6_ce",     output_clock_enable, 32'h0);
    check("t6_bus",    output_bus,          32'h0);
    wait_drain();
    check("t6_bank1",  bank[1], 32'h0);
    input_clr_req = '0;
`endif

    repeat (2) @(negedge clock);
    check("final_queue_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
